// File: rtl/servant_ram_arbiter.sv
// Round-robin Wishbone arbiter that shares the servant RAM between the ibus and the dbus.
// Optional bus-hang watchdog is enabled with `define WB_ARB_TIMEOUT_EN.
module servant_ram_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  output logic          o_ibus_err,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic          o_dbus_err,
  output logic [AW-1:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  output logic [1:0]    o_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Counts BUSY cycles; IDLE keeps it cleared so every grant starts from zero.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      cnt <= {CW{1'b0}};
    end else if (state == IDLE) begin
      cnt <= {CW{1'b0}};
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // An ack arriving on the timeout cycle completes the access normally.
  assign timeout_hit = (state != IDLE) && (cnt == CW'(TIMEOUT)) && !i_s_ack;
  assign o_ibus_err  = (state == BUSY_I) && timeout_hit;
  assign o_dbus_err  = (state == BUSY_D) && timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign o_ibus_err  = 1'b0;
  assign o_dbus_err  = 1'b0;
`endif

  // Grant FSM; last_d remembers the previous owner so ties alternate.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_ibus_cyc && (!i_dbus_cyc || last_d)) begin
            state <= BUSY_I;
          end else if (i_dbus_cyc) begin
            state <= BUSY_D;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_I: begin
          if (i_s_ack || !i_ibus_cyc || timeout_hit) begin
            state  <= IDLE;
            last_d <= 1'b0;
          end else begin
            state <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (i_s_ack || !i_dbus_cyc || timeout_hit) begin
            state  <= IDLE;
            last_d <= 1'b1;
          end else begin
            state <= BUSY_D;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side mux and acks follow the granted master combinationally.
  always_comb begin
    o_s_adr    = {AW{1'b0}};
    o_s_dat    = 32'h0000_0000;
    o_s_sel    = 4'h0;
    o_s_we     = 1'b0;
    o_s_cyc    = 1'b0;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    case (state)
      BUSY_I: begin
        o_s_adr    = i_ibus_adr;
        o_s_sel    = 4'hF;
        o_s_cyc    = i_ibus_cyc && !timeout_hit;
        o_ibus_ack = i_s_ack;
      end
      BUSY_D: begin
        o_s_adr    = i_dbus_adr;
        o_s_dat    = i_dbus_dat;
        o_s_sel    = i_dbus_sel;
        o_s_we     = i_dbus_we;
        o_s_cyc    = i_dbus_cyc && !timeout_hit;
        o_dbus_ack = i_s_ack;
      end
      default: begin
        o_s_cyc = 1'b0;
      end
    endcase
  end

  assign o_ibus_rdt = i_s_rdt;
  assign o_dbus_rdt = i_s_rdt;
  assign o_grant    = {state == BUSY_D, state == BUSY_I};

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter with a one-cycle-latency RAM model.
module tb_servant_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus_adr = 32'h0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack, ibus_err;
  logic [31:0] dbus_adr = 32'h0;
  logic [31:0] dbus_dat = 32'h0;
  logic [3:0]  dbus_sel = 4'h0;
  logic        dbus_we = 1'b0;
  logic        dbus_cyc = 1'b0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack, dbus_err;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc;
  logic [31:0] s_rdt;
  logic        s_ack;
  logic [1:0]  grant;
  logic        noack = 1'b0;
  logic [31:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  servant_ram_arbiter #(.AW(32), .TIMEOUT(15)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack), .o_ibus_err(ibus_err),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
    .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
    .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack), .o_dbus_err(dbus_err),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_cyc(s_cyc), .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_grant(grant)
  );

  always #5 clk = ~clk;

  // RAM model: acks the cycle after o_s_cyc, byte-enabled writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_rdt <= 32'h0;
    end else begin
      s_ack <= s_cyc && !s_ack && !noack;
      if (s_cyc && !s_ack) begin
        s_rdt <= mem[s_adr[7:2]];
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[7:2]][b*8 +: 8] <= s_dat[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h0055_0023;

    // Reset state
    tick(); tick();
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_s_cyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_iack", {31'h0, ibus_ack}, 32'h0);
    rst_n = 1'b1;

    // Single ibus fetch
    tick();
    ibus_adr = 32'h10; ibus_cyc = 1'b1; #1;
    chk("f_c0_scyc", {31'h0, s_cyc}, 32'h0);
    tick();
    chk("f_c1_scyc", {31'h0, s_cyc}, 32'h1);
    chk("f_c1_grant", {30'h0, grant}, 32'h1);
    chk("f_c1_adr", s_adr, 32'h10);
    chk("f_c1_sel", {28'h0, s_sel}, 32'hF);
    chk("f_c1_we", {31'h0, s_we}, 32'h0);
    tick();
    chk("f_c2_iack", {31'h0, ibus_ack}, 32'h1);
    chk("f_c2_rdt", ibus_rdt, 32'h0055_0023);
    chk("f_c2_dack", {31'h0, dbus_ack}, 32'h0);
    ibus_cyc = 1'b0;
    tick();
    chk("f_c3_grant", {30'h0, grant}, 32'h0);
    chk("f_c3_scyc", {31'h0, s_cyc}, 32'h0);

    // dbus write then read
    dbus_adr = 32'h40; dbus_dat = 32'hA5A5_A5A5; dbus_sel = 4'b0011;
    dbus_we = 1'b1; dbus_cyc = 1'b1;
    tick();
    chk("w_c1_grant", {30'h0, grant}, 32'h2);
    chk("w_c1_we", {31'h0, s_we}, 32'h1);
    chk("w_c1_sel", {28'h0, s_sel}, 32'h3);
    chk("w_c1_dat", s_dat, 32'hA5A5_A5A5);
    tick();
    chk("w_c2_dack", {31'h0, dbus_ack}, 32'h1);
    chk("w_c2_iack", {31'h0, ibus_ack}, 32'h0);
    dbus_we = 1'b0;
    tick();
    chk("r_c3_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("r_c4_grant", {30'h0, grant}, 32'h2);
    chk("r_c4_we", {31'h0, s_we}, 32'h0);
    tick();
    chk("r_c5_dack", {31'h0, dbus_ack}, 32'h1);
    chk("r_c5_rdt", dbus_rdt, 32'h0000_A5A5);
    dbus_cyc = 1'b0;
    tick();
    chk("r_c6_grant", {30'h0, grant}, 32'h0);

    // Contention from reset: I, D, I then dbus abort
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ibus_adr = 32'h10; ibus_cyc = 1'b1;
    dbus_adr = 32'h40; dbus_cyc = 1'b1;
    tick();
    chk("c1_grant", {30'h0, grant}, 32'h1);
    tick();
    chk("c2_iack", {31'h0, ibus_ack}, 32'h1);
    chk("c2_dack", {31'h0, dbus_ack}, 32'h0);
    chk("c2_rdt", ibus_rdt, 32'h0055_0023);
    tick();
    chk("c3_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("c4_grant", {30'h0, grant}, 32'h2);
    tick();
    chk("c5_dack", {31'h0, dbus_ack}, 32'h1);
    chk("c5_iack", {31'h0, ibus_ack}, 32'h0);
    chk("c5_rdt", dbus_rdt, 32'h0000_A5A5);
    tick();
    chk("c6_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("c7_grant", {30'h0, grant}, 32'h1);
    tick();
    chk("c8_iack", {31'h0, ibus_ack}, 32'h1);
    tick();
    chk("c9_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("c10_grant", {30'h0, grant}, 32'h2);
    dbus_cyc = 1'b0; #1;
    chk("ab_scyc", {31'h0, s_cyc}, 32'h0);
    chk("ab_dack", {31'h0, dbus_ack}, 32'h0);
    tick();
    chk("ab_idle", {30'h0, grant}, 32'h0);
    chk("ab_dack2", {31'h0, dbus_ack}, 32'h0);
    tick();
    chk("ab_igrant", {30'h0, grant}, 32'h1);

    // Asynchronous reset mid BUSY_I
    rst_n = 1'b0; #1;
    chk("ar_scyc", {31'h0, s_cyc}, 32'h0);
    chk("ar_grant", {30'h0, grant}, 32'h0);
    dbus_cyc = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_tie", {30'h0, grant}, 32'h1);
    tick();
    chk("ar_iack", {31'h0, ibus_ack}, 32'h1);
    ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    tick();
    chk("ar_idle", {30'h0, grant}, 32'h0);

    // Non-acking slave on dbus
    noack = 1'b1;
    dbus_cyc = 1'b1;
    tick();
    chk("to_c1_grant", {30'h0, grant}, 32'h2);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 2; k <= 15; k++) begin
      tick();
      chk("to_wait_err", {31'h0, dbus_err}, 32'h0);
    end
    tick();
    chk("to_c16_derr", {31'h0, dbus_err}, 32'h1);
    chk("to_c16_ierr", {31'h0, ibus_err}, 32'h0);
    chk("to_c16_scyc", {31'h0, s_cyc}, 32'h0);
    tick();
    chk("to_c17_grant", {30'h0, grant}, 32'h0);
    chk("to_c17_derr", {31'h0, dbus_err}, 32'h0);
`else
    for (int k = 2; k <= 20; k++) begin
      tick();
      chk("nt_grant", {30'h0, grant}, 32'h2);
      chk("nt_derr", {31'h0, dbus_err}, 32'h0);
    end
`endif
    dbus_cyc = 1'b0;
    noack = 1'b0;
    tick(); tick();
    chk("end_grant", {30'h0, grant}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
